// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder with a fixed
// request-to-response latency. Requests are accepted only in IDLE, held through
// BUSY while a down-counter runs out, and answered with a one-cycle strobe in RESP.
// A store is committed to the array on the edge that leaves RESP, so a reset
// that lands before then leaves the array untouched.
//
// Optional build macro: DMEM_ALIGN_CHECK_EN
//   defined   - requests with addr[1:0] != 0 complete with mem_err=1, dout=0
//               and no array write, with the same latency as any other request.
//   undefined - addr[1:0] is ignored and mem_err is always 0.
//
// Handshake: a request transfers on a rising clk edge where is_ready=1,
// is_input_valid=1 and (mem_read | mem_write)=1. The responder never queues, and
// is_input_valid is ignored while is_ready=0. The response is a single-cycle
// strobe on is_output_valid with no back-pressure. dout and mem_err are only
// meaningful while is_output_valid=1, and dout is held at 0 at all other times.

module dmem_responder #(
    parameter int LATENCY = 4,
    parameter int DEPTH   = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        is_input_valid,
    input  logic [31:0] addr,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] din,
    output logic        is_ready,
    output logic        is_output_valid,
    output logic [31:0] dout,
    output logic        mem_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state;
    logic [3:0]    cnt;

    // Captured transaction; stable from accept until the edge leaving RESP.
    logic [AW-1:0] idx_q;
    logic [31:0]   din_q;
    logic          wr_q;
    logic          err_q;

    // Registered outputs.
    logic          ready_q;
    logic          valid_q;
    logic [31:0]   dout_q;
    logic          err_out_q;

    logic [31:0]   mem [DEPTH];

    logic          accept;
    logic [AW-1:0] req_idx;
    logic          req_err;

    // Response source: the live request when entering RESP straight from IDLE
    // (LATENCY=1), otherwise the captured copy.
    logic [AW-1:0] src_idx;
    logic [31:0]   src_din;
    logic          src_wr;
    logic          src_err;
    logic [31:0]   resp_data;

    // Address bits above the word index wrap away; the byte offset only
    // matters when alignment checking is built in.
    logic          unused_addr_bits;
    assign unused_addr_bits = ^{addr[31:AW+2], addr[1:0]};

    assign accept  = (state == IDLE) && is_input_valid && (mem_read || mem_write);
    assign req_idx = addr[AW+1:2];

`ifdef DMEM_ALIGN_CHECK_EN
    assign req_err = (addr[1:0] != 2'b00);
`else
    assign req_err = 1'b0;
`endif

    // Pick the transaction that is about to be answered and form its data.
    always_comb begin
        src_idx = idx_q;
        src_din = din_q;
        src_wr  = wr_q;
        src_err = err_q;
        if (state == IDLE) begin
            src_idx = req_idx;
            src_din = din;
            src_wr  = mem_write;
            src_err = req_err;
        end
        if (src_err) begin
            resp_data = 32'h0;
        end else if (src_wr) begin
            resp_data = src_din;
        end else begin
            resp_data = mem[src_idx];
        end
    end

    // Control FSM with capture registers and registered response outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            idx_q     <= '0;
            din_q     <= 32'h0;
            wr_q      <= 1'b0;
            err_q     <= 1'b0;
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
            dout_q    <= 32'h0;
            err_out_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        idx_q   <= req_idx;
                        din_q   <= din;
                        wr_q    <= mem_write;  // read+write together is a store
                        err_q   <= req_err;
                        ready_q <= 1'b0;
                        if (LATENCY == 1) begin
                            state     <= RESP;
                            cnt       <= 4'd0;
                            valid_q   <= 1'b1;
                            dout_q    <= resp_data;
                            err_out_q <= src_err;
                        end else begin
                            state <= BUSY;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                BUSY: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state     <= RESP;
                        valid_q   <= 1'b1;
                        dout_q    <= resp_data;
                        err_out_q <= src_err;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    ready_q   <= 1'b1;
                    valid_q   <= 1'b0;
                    dout_q    <= 32'h0;
                    err_out_q <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= 4'd0;
                    ready_q   <= 1'b1;
                    valid_q   <= 1'b0;
                    dout_q    <= 32'h0;
                    err_out_q <= 1'b0;
                end
            endcase
        end
    end

    // Commit a good store on the edge leaving RESP; the array is never reset.
    always_ff @(posedge clk) begin
        if ((state == RESP) && wr_q && !err_q) begin
            mem[idx_q] <= din_q;
        end
    end

    assign is_ready        = ready_q;
    assign is_output_valid = valid_q;
    assign dout            = dout_q;
    assign mem_err         = err_out_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed testbench for dmem_responder. Instance u_dut4 uses LATENCY=4 and
// instance u_dut1 uses LATENCY=1; both have DEPTH=1024. Both instances share the
// request bus, and tb_sel steers is_input_valid and the observed outputs.

module tb_dmem_responder;

    logic        clk;
    logic        reset;
    logic        tb_sel;       // 0: LATENCY=4 instance, 1: LATENCY=1 instance
    logic        tb_valid;
    logic [31:0] addr;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] din;

    logic        ready4, valid4, err4;
    logic [31:0] dout4;
    logic        ready1, valid1, err1;
    logic [31:0] dout1;

    logic        c_ready, c_valid, c_err;
    logic [31:0] c_dout;

    logic [31:0] exp_q[$];
    int          checks;
    int          failures;

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    dmem_responder #(.LATENCY(4), .DEPTH(1024)) u_dut4 (
        .clk             (clk),
        .reset           (reset),
        .is_input_valid  (tb_valid && !tb_sel),
        .addr            (addr),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .din             (din),
        .is_ready        (ready4),
        .is_output_valid (valid4),
        .dout            (dout4),
        .mem_err         (err4)
    );

    dmem_responder #(.LATENCY(1), .DEPTH(1024)) u_dut1 (
        .clk             (clk),
        .reset           (reset),
        .is_input_valid  (tb_valid && tb_sel),
        .addr            (addr),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .din             (din),
        .is_ready        (ready1),
        .is_output_valid (valid1),
        .dout            (dout1),
        .mem_err         (err1)
    );

    assign c_ready = tb_sel ? ready1 : ready4;
    assign c_valid = tb_sel ? valid1 : valid4;
    assign c_dout  = tb_sel ? dout1  : dout4;
    assign c_err   = tb_sel ? err1   : err4;

    // Driver: one transaction from accept through the first IDLE cycle after
    // RESP. Called at a negedge, returns at a negedge. With poke set, a load to
    // 0x20 is presented while the responder is busy.
    task automatic do_txn(input bit sel, input bit rd, input bit wr,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_d, input bit exp_e,
                          input bit poke, input string name);
        int lat;
        int w;
        logic [31:0] exp_v;
        lat = sel ? 1 : 4;
        tb_sel = sel;
        w = 0;
        while (c_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (c_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s ready_timeout got=%b exp=1", name, c_ready);
        end
        exp_q.push_back(exp_d);
        tb_valid  = 1'b1;
        addr      = a;
        din       = d;
        mem_read  = rd;
        mem_write = wr;
        @(posedge clk);
        #1;
        // Scramble the bus: the captured request must be unaffected.
        tb_valid  = 1'b0;
        addr      = $urandom;
        din       = $urandom;
        mem_read  = ~rd;
        mem_write = ~wr;
        for (int j = 1; j <= lat + 1; j++) begin
            @(negedge clk);
            if (poke && j == lat) tb_valid = 1'b0;
            checks++;
            if (c_valid !== 1'((j == lat))) begin
                failures++;
                $display("FAIL %s valid cyc=%0d got=%b exp=%b", name, j, c_valid, (j == lat));
            end
            checks++;
            if (c_ready !== 1'((j == lat + 1))) begin
                failures++;
                $display("FAIL %s ready cyc=%0d got=%b exp=%b", name, j, c_ready, (j == lat + 1));
            end
            if (j == lat) begin
                exp_v = exp_q.pop_front();
                checks++;
                if (c_dout !== exp_v) begin
                    failures++;
                    $display("FAIL %s dout got=%h exp=%h", name, c_dout, exp_v);
                end
                checks++;
                if (c_err !== exp_e) begin
                    failures++;
                    $display("FAIL %s mem_err got=%b exp=%b", name, c_err, exp_e);
                end
            end else begin
                checks++;
                if (c_dout !== 32'h0) begin
                    failures++;
                    $display("FAIL %s dout_idle cyc=%0d got=%h exp=00000000", name, j, c_dout);
                end
            end
            if (poke && j == 1) begin
                tb_valid  = 1'b1;
                mem_read  = 1'b1;
                mem_write = 1'b0;
                addr      = 32'h20;
            end
        end
        tb_valid = 1'b0;
    endtask

    task automatic test_reset();
        tb_sel    = 1'b0;
        tb_valid  = 1'b0;
        addr      = 32'h0;
        din       = 32'h0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        reset     = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({ready4, valid4, dout4, err4} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
            failures++;
            $display("FAIL reset_hold4 got=r%b v%b d%h e%b exp=r1 v0 d00000000 e0", ready4, valid4, dout4, err4);
        end
        checks++;
        if ({ready1, valid1, dout1, err1} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
            failures++;
            $display("FAIL reset_hold1 got=r%b v%b d%h e%b exp=r1 v0 d00000000 e0", ready1, valid1, dout1, err1);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({ready4, valid4, dout4, err4} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
            failures++;
            $display("FAIL reset_release got=r%b v%b d%h e%b exp=r1 v0 d00000000 e0", ready4, valid4, dout4, err4);
        end
    endtask

    task automatic test_store_load();
        do_txn(1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, "store_10");
        do_txn(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, "load_10");
        // read and write together behave as a store
        do_txn(1'b0, 1'b1, 1'b1, 32'h14, 32'h0BADF00D, 32'h0BADF00D, 1'b0, 1'b0, "rw_store_14");
        do_txn(1'b0, 1'b1, 1'b0, 32'h14, 32'h0, 32'h0BADF00D, 1'b0, 1'b0, "load_14");
    endtask

    task automatic test_busy_ignore();
        do_txn(1'b0, 1'b0, 1'b1, 32'h20, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 1'b0, "store_20");
        do_txn(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1, "busy_load_10");
        do_txn(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0, 1'b0, "load_20");
    endtask

    task automatic test_wrap_lat1();
        do_txn(1'b1, 1'b0, 1'b1, 32'h1000, 32'h12345678, 32'h12345678, 1'b0, 1'b0, "l1_store_1000");
        do_txn(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 32'h12345678, 1'b0, 1'b0, "l1_load_0");
        do_txn(1'b1, 1'b0, 1'b1, 32'hFFC, 32'h5A5A0001, 32'h5A5A0001, 1'b0, 1'b0, "l1_store_ffc");
        do_txn(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'h5A5A0001, 1'b0, 1'b0, "l1_load_top");
        tb_sel = 1'b0;
    endtask

    task automatic test_reset_mid_store();
        do_txn(1'b0, 1'b0, 1'b1, 32'h8, 32'h0, 32'h0, 1'b0, 1'b0, "store_8_zero");
        tb_sel    = 1'b0;
        tb_valid  = 1'b1;
        addr      = 32'h8;
        din       = 32'hAAAA5555;
        mem_read  = 1'b0;
        mem_write = 1'b1;
        @(posedge clk);
        #1;
        tb_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (ready4 !== 1'b0) begin
            failures++;
            $display("FAIL midstore_busy ready got=%b exp=0", ready4);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({ready4, valid4, dout4, err4} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
            failures++;
            $display("FAIL midstore_async got=r%b v%b d%h e%b exp=r1 v0 d00000000 e0", ready4, valid4, dout4, err4);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        do_txn(1'b0, 1'b1, 1'b0, 32'h8, 32'h0, 32'h0, 1'b0, 1'b0, "load_8_after_abort");
        do_txn(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, "load_10_persist");
    endtask

    task automatic test_align();
        do_txn(1'b0, 1'b0, 1'b1, 32'h4, 32'h11112222, 32'h11112222, 1'b0, 1'b0, "store_4");
`ifdef DMEM_ALIGN_CHECK_EN
        do_txn(1'b0, 1'b0, 1'b1, 32'h6, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0, "misaligned_store_6");
        do_txn(1'b0, 1'b1, 1'b0, 32'h4, 32'h0, 32'h11112222, 1'b0, 1'b0, "load_4_unchanged");
`else
        do_txn(1'b0, 1'b0, 1'b1, 32'h6, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, "offset_store_6");
        do_txn(1'b0, 1'b1, 1'b0, 32'h4, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b0, "load_4_updated");
`endif
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_store_load();
        test_busy_ignore();
        test_wrap_lat1();
        test_reset_mid_store();
        test_align();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
